// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: operand forwarding and hazard control for a 5-stage pipeline.
// Shadows the EX/MEM/WB register usage of in-flight instructions and decides,
// every cycle, the EX operand sources and the stall/flush controls.
// Build option: define FWD_HAZARD_FORWARD_EN to enable forwarding with load-use
// stalls only; without it the unit stalls on any pending producer (max 3 cycles).
module forward_hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        ex_branch_taken,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_id,
    output logic        flush_ex,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } stage_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    stage_t      ex_q;
    stage_t      mem_q;
    stage_t      wb_q;
    stage_t      ex_d;
    state_t      state_q;
    state_t      state_d;
    logic [15:0] stall_count_q;
    logic [15:0] stall_count_next;
    logic        hazard;
    logic        branch;
    logic        stall;
    logic        unused_wb;

    // A stage produces register r only if it is live, writes back, and r is not x0.
    function automatic logic produces(input stage_t s, input logic [4:0] r);
        return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == r);
    endfunction

    // The WB stage is only ever consulted for its destination.
    assign unused_wb = ^{wb_q.rs1, wb_q.rs2, wb_q.memread};

    // Branch resolution and reset both override any stall decision.
    assign branch = ex_branch_taken && !rst;
    assign stall  = hazard && !branch;

`ifdef FWD_HAZARD_FORWARD_EN
    // Only a load in EX cannot be forwarded in time, so it is the sole stall source.
    always_comb begin
        hazard = 1'b0;
        if (!rst && id_valid && ex_q.memread) begin
            hazard = (id_rs1_used && produces(ex_q, id_rs1)) ||
                     (id_rs2_used && produces(ex_q, id_rs2));
        end
    end

    // Pick the youngest producer for each EX operand: MEM beats WB.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (!rst) begin
            if (produces(mem_q, ex_q.rs1)) begin
                fwd_a_sel = 2'b10;
            end else if (produces(wb_q, ex_q.rs1)) begin
                fwd_a_sel = 2'b01;
            end
            if (produces(mem_q, ex_q.rs2)) begin
                fwd_b_sel = 2'b10;
            end else if (produces(wb_q, ex_q.rs2)) begin
                fwd_b_sel = 2'b01;
            end
        end
    end
`else
    logic [1:0] stall_run_q;

    // Without forwarding, any pending producer blocks ID, capped at 3 stalls in a row.
    always_comb begin
        hazard = 1'b0;
        if (!rst && id_valid && (stall_run_q != 2'd3)) begin
            hazard = (id_rs1_used && (produces(ex_q, id_rs1) ||
                                      produces(mem_q, id_rs1) ||
                                      produces(wb_q, id_rs1))) ||
                     (id_rs2_used && (produces(ex_q, id_rs2) ||
                                      produces(mem_q, id_rs2) ||
                                      produces(wb_q, id_rs2)));
        end
    end

    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;

    // Length of the current run of consecutive stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_run_q <= 2'd0;
        end else if (stall) begin
            stall_run_q <= stall_run_q + 2'd1;
        end else begin
            stall_run_q <= 2'd0;
        end
    end
`endif

    // Stall holds PC and IF/ID; a taken branch clears IF/ID; either bubbles ID/EX.
    always_comb begin
        stall_if = stall;
        stall_id = stall;
        flush_id = branch;
        flush_ex = stall || branch;
    end

    // Next EX contents: the ID instruction, or an all-zero bubble.
    always_comb begin
        ex_d = '0;
        if (!stall && !branch && id_valid) begin
            ex_d = {id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread};
        end
    end

    // Shadow pipeline advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Record what happened this cycle: flush outranks stall.
    always_comb begin
        state_d = ST_RUN;
        if (branch) begin
            state_d = ST_FLUSH;
        end else if (stall) begin
            state_d = ST_STALL;
        end
    end

    // Saturating stall counter next value.
    always_comb begin
        stall_count_next = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_next = stall_count_q + 16'd1;
        end
    end

    // State and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_next;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock; the sole clock domain.
REQ-002 SHALL provide: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide: id_valid  input  1  ID stage holds a real instruction.
REQ-004 SHALL provide: id_rs1, id_rs2  input  5 each  ID source register numbers.
REQ-005 SHALL provide: id_rs1_used, id_rs2_used  input  1 each  source operand actually read.
REQ-006 SHALL provide: id_rd  input  5  ID destination register.
REQ-007 SHALL provide: id_regwrite, id_memread  input  1 each  ID writes the register file / is a load.
REQ-008 SHALL provide: ex_branch_taken  input  1  branch or jump resolved taken in EX this cycle.
REQ-009 SHALL provide: fwd_a_sel, fwd_b_sel  output  2 each  EX operand select: 00 register file, 01 WB result, 10 MEM result, 11 never driven.
REQ-010 SHALL provide: stall_if, stall_id  output  1 each  hold PC / hold the IF/ID register.
REQ-011 SHALL provide: flush_id, flush_ex  output  1 each  clear the IF/ID register / insert a bubble into ID/EX.
REQ-012 SHALL provide: state  output  2  00 RUN, 01 STALL, 10 FLUSH.
REQ-013 SHALL provide: stall_count  output  16  saturating count of stall cycles.

Function
REQ-014 SHALL keep shadow stages EX, MEM and WB, each holding {valid, rs1, rs2, rd, regwrite, memread}, and advance them on every clk edge: WB<=MEM, MEM<=EX.
REQ-015 SHALL load EX from the ID inputs when the current cycle has no stall and no flush, and SHALL load EX with valid=0 (bubble) otherwise.
REQ-016 SHALL treat a stage as a producer only when valid=1, regwrite=1 and rd!=0; register x0 is never a hazard and is never forwarded.
REQ-017 SHALL compute fwd_a_sel from EX.rs1 combinationally: 10 if MEM produces it, else 01 if WB produces it, else 00. MEM has priority over WB.
REQ-018 SHALL compute fwd_b_sel identically from EX.rs2.
REQ-019 SHALL raise a load-use hazard in the same cycle when id_valid=1, EX is a producer with memread=1, and a used ID source equals EX.rd.
REQ-020 On a hazard with ex_branch_taken=0, SHALL assert stall_if=stall_id=flush_ex=1 and flush_id=0 for exactly one cycle per hazard instance.
REQ-021 With ex_branch_taken=1, SHALL assert flush_id=flush_ex=1 and stall_if=stall_id=0, regardless of any hazard; branch wins over stall.
REQ-022 With neither a hazard nor a branch, SHALL drive all stall and flush outputs to 0.
REQ-023 SHALL register state at each edge: FLUSH if a branch occurred, else STALL if a stall occurred, else RUN.
REQ-024 SHALL increment stall_count on each cycle with stall_id=1, saturating at 16'hFFFF with no wrap.
REQ-025 SHALL assign every output a defined value every cycle, with no latches and no X on outputs after reset.

Reset
REQ-026 While rst=1 at a clk edge, SHALL clear every shadow stage valid bit, set state=00 and stall_count=0.
REQ-027 SHALL produce outputs during reset and in the first cycle after it that equal those of an empty pipeline: fwd sels 00, all stall and flush outputs 0.
REQ-028 SHALL discard any in-progress stall when reset is asserted mid-stall, with no residual stall after release.

Configuration
REQ-029 Macro FWD_HAZARD_FORWARD_EN defined: forwarding per REQ-017/018, and stalls are limited to load-use per REQ-019.
REQ-030 Macro FWD_HAZARD_FORWARD_EN undefined:
- fwd_a_sel and fwd_b_sel are constant 00.
- A hazard is raised whenever a used ID source matches the rd of any producer in EX, MEM or WB.
- The stall repeats each cycle until no match remains, up to 3 consecutive cycles.
- Branch priority per REQ-021 is unchanged.

Verification
REQ-031 Sequence "add x5" then "sub x6,x5,x1" -> next cycle fwd_a_sel=10; one cycle later, with a dependent third instruction reading x5, fwd_a_sel=01; no stall.
REQ-032 Sequence "lw x7" then "add x8,x7,x7" -> one cycle with stall_if=stall_id=flush_ex=1 and state=01 next; then fwd_a_sel=fwd_b_sel=01.
REQ-033 Load-use hazard present with ex_branch_taken=1 in the same cycle -> flush_id=flush_ex=1, stall_id=0, state=10 next, stall_count unchanged.
REQ-034 "addi x0" followed by a reader of x0 -> fwd sels 00, no stall.
REQ-035 Reset asserted during a load-use stall -> next cycle all outputs 0 and stall_count=0.
REQ-036 Build without FWD_HAZARD_FORWARD_EN, "add x5" then a reader of x5 -> exactly 3 stall cycles, fwd sels stay 00; stall_count preloaded to FFFE reads FFFF after the stalls.
